// File: rtl/multi_instr_scan.sv
// Control-flow scanner for a realigned fetch block: classifies each slot,
// picks the first control-flow instruction, predicts its target and keeps
// a small circular return-address stack. One registered output stage.

package config_pkg;
    typedef struct packed {
        int unsigned VLEN;
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 64, XLEN: 64};
endpackage

module multi_instr_scan #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned NR_SLOTS  = 4,
    parameter int unsigned RAS_DEPTH = 2,
    localparam int unsigned VLEN     = CVA6Cfg.VLEN,
    localparam int unsigned SLOT_W   = (NR_SLOTS > 1) ? $clog2(NR_SLOTS) : 1,
    localparam int unsigned CNT_W    = $clog2(RAS_DEPTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [NR_SLOTS*32-1:0]   instr_i,
    input  logic [NR_SLOTS*VLEN-1:0] addr_i,
    input  logic [NR_SLOTS-1:0]      slot_valid_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     cf_found_o,
    output logic [SLOT_W-1:0]        cf_slot_o,
    output logic [2:0]               cf_type_o,
    output logic [VLEN-1:0]          cf_target_o,
    output logic                     cf_target_valid_o,
    output logic [CNT_W-1:0]         ras_count_o
);

    localparam int unsigned PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam bit          CJAL_EN = (CVA6Cfg.XLEN == 32);

    typedef enum logic [2:0] {
        CF_NONE     = 3'd0,
        CF_BRANCH   = 3'd1,
        CF_JUMP     = 3'd2,
        CF_CALL     = 3'd3,
        CF_RETURN   = 3'd4,
        CF_INDIRECT = 3'd5
    } cf_type_e;

    typedef struct packed {
        cf_type_e        kind;
        logic            push;     // writes the link address onto the RAS
        logic            pop;      // removes the RAS top
        logic            imm_tgt;  // target is pc + immediate
        logic [VLEN-1:0] target;
        logic [VLEN-1:0] link;
    } slot_dec_t;

    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    // A JALR that both returns and links is typed RETURN but still pushes,
    // giving the pop-then-push coroutine behaviour.
    function automatic slot_dec_t decode_slot(input logic [31:0] ins, input logic [VLEN-1:0] pc);
        slot_dec_t         d;
        logic signed [20:0] imm;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2c;
        d    = '0;
        imm  = '0;
        rd   = ins[11:7];
        rs1  = ins[19:15];
        rs2c = ins[6:2];
        if (ins[1:0] == 2'b11) begin
            d.link = pc + VLEN'(4);
            case (ins[6:0])
                7'b1100011: begin
                    d.kind    = CF_BRANCH;
                    d.imm_tgt = 1'b1;
                    imm       = {{8{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                end
                7'b1101111: begin
                    d.push    = is_link_reg(rd);
                    d.kind    = is_link_reg(rd) ? CF_CALL : CF_JUMP;
                    d.imm_tgt = 1'b1;
                    imm       = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                end
                7'b1100111: begin
                    d.pop  = is_link_reg(rs1) && (rd != rs1);
                    d.push = is_link_reg(rd);
                    d.kind = d.pop ? CF_RETURN : (d.push ? CF_CALL : CF_INDIRECT);
                end
                default: ;
            endcase
        end else begin
            d.link = pc + VLEN'(2);
            if (ins[1:0] == 2'b01) begin
                case (ins[15:13])
                    3'b101: begin
                        d.kind    = CF_JUMP;
                        d.imm_tgt = 1'b1;
                        imm       = {{9{ins[12]}}, ins[12], ins[8], ins[10:9], ins[6], ins[7],
                                     ins[2], ins[11], ins[5:3], 1'b0};
                    end
                    3'b001: begin
                        if (CJAL_EN) begin
                            d.kind    = CF_CALL;
                            d.push    = 1'b1;
                            d.imm_tgt = 1'b1;
                            imm       = {{9{ins[12]}}, ins[12], ins[8], ins[10:9], ins[6], ins[7],
                                         ins[2], ins[11], ins[5:3], 1'b0};
                        end
                    end
                    3'b110, 3'b111: begin
                        d.kind    = CF_BRANCH;
                        d.imm_tgt = 1'b1;
                        imm       = {{12{ins[12]}}, ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0};
                    end
                    default: ;
                endcase
            end else if (ins[1:0] == 2'b10 && ins[15:13] == 3'b100 && rs2c == 5'd0 && rd != 5'd0) begin
                if (ins[12]) begin
                    d.kind = CF_CALL;
                    d.push = 1'b1;
                end else begin
                    d.pop  = is_link_reg(rd);
                    d.kind = is_link_reg(rd) ? CF_RETURN : CF_INDIRECT;
                end
            end
        end
        d.target = pc + {{(VLEN-21){imm[20]}}, imm};
        return d;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - PTR_W'(1);
    endfunction

    slot_dec_t         dec [NR_SLOTS];
    logic              sel_found;
    logic [SLOT_W-1:0] sel_idx;
    slot_dec_t         sel_dec;
    logic [VLEN-1:0]   res_target;
    logic              res_tv;
    logic              accept;

    logic [VLEN-1:0]   ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;
    logic [PTR_W-1:0]  ras_ptr_nxt;
    logic [CNT_W-1:0]  ras_cnt;
    logic [CNT_W-1:0]  ras_cnt_nxt;
    logic              ras_we;

    logic              vld_p1;
    logic              found_p1;
    logic [SLOT_W-1:0] slot_p1;
    cf_type_e          type_p1;
    logic [VLEN-1:0]   target_p1;
    logic              tv_p1;

    // Decode every slot in parallel.
    always_comb begin
        for (int k = 0; k < NR_SLOTS; k++) begin
            dec[k] = decode_slot(instr_i[32*k +: 32], addr_i[VLEN*k +: VLEN]);
        end
    end

    // Priority pick of the lowest valid control-flow slot.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_dec   = '0;
        for (int k = 0; k < NR_SLOTS; k++) begin
            if (!sel_found && slot_valid_i[k] && dec[k].kind != CF_NONE) begin
                sel_found = 1'b1;
                sel_idx   = SLOT_W'(k);
                sel_dec   = dec[k];
            end
        end
    end

    // Target prediction: RAS top for returns, pc+imm for direct transfers.
    always_comb begin
        res_target = '0;
        res_tv     = 1'b0;
        if (sel_found) begin
            if (sel_dec.kind == CF_RETURN) begin
                if (ras_cnt != '0) begin
                    res_target = ras_mem[ras_ptr];
                    res_tv     = 1'b1;
                end
            end else if (sel_dec.imm_tgt) begin
                res_target = sel_dec.target;
                res_tv     = 1'b1;
            end
        end
    end

    assign ready_o = (~vld_p1 | ready_i) & ~flush_i & ~rst_i;
    assign accept  = valid_i & ready_o;

    // RAS next state: pop first, then push; a full stack wraps onto its oldest entry.
    always_comb begin
        ras_ptr_nxt = ras_ptr;
        ras_cnt_nxt = ras_cnt;
        ras_we      = 1'b0;
        if (accept && sel_found) begin
            if (sel_dec.pop && ras_cnt != '0) begin
                ras_ptr_nxt = ptr_dec(ras_ptr);
                ras_cnt_nxt = ras_cnt - CNT_W'(1);
            end
            if (sel_dec.push) begin
                ras_ptr_nxt = ptr_inc(ras_ptr_nxt);
                ras_we      = 1'b1;
                if (ras_cnt_nxt != CNT_W'(RAS_DEPTH)) begin
                    ras_cnt_nxt = ras_cnt_nxt + CNT_W'(1);
                end
            end
        end
    end

    // RAS pointer and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else begin
            ras_ptr <= ras_ptr_nxt;
            ras_cnt <= ras_cnt_nxt;
        end
    end

    // RAS entry storage; contents are only meaningful below the count.
    always_ff @(posedge clk_i) begin
        if (ras_we) begin
            ras_mem[ras_ptr_nxt] <= sel_dec.link;
        end
    end

    // Output stage p1: load on accept, drop on retire or flush, hold on stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1    <= 1'b0;
            found_p1  <= 1'b0;
            slot_p1   <= '0;
            type_p1   <= CF_NONE;
            target_p1 <= '0;
            tv_p1     <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            found_p1  <= sel_found;
            slot_p1   <= sel_idx;
            type_p1   <= sel_dec.kind;
            target_p1 <= res_target;
            tv_p1     <= res_tv;
        end else if (ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign valid_o           = vld_p1;
    assign cf_found_o        = found_p1;
    assign cf_slot_o         = slot_p1;
    assign cf_type_o         = type_p1;
    assign cf_target_o       = target_p1;
    assign cf_target_valid_o = tv_p1;
    assign ras_count_o       = ras_cnt;

endmodule

// File: tb/tb_multi_instr_scan.sv
// Bench for multi_instr_scan: directed scenarios followed by randomized
// blocks, all compared against a queue-based behavioural model.
module tb_multi_instr_scan;
    localparam int NS    = 4;
    localparam int VL    = 64;
    localparam int DEPTH = 2;
    localparam int XL    = int'(config_pkg::cva6_cfg_empty.XLEN);

    logic            clk = 1'b0;
    logic            rst, flush, vin, rdy_o, vout, rdy_in;
    logic [NS*32-1:0] instr;
    logic [NS*VL-1:0] addr;
    logic [NS-1:0]   svalid;
    logic            found, ctv;
    logic [1:0]      cslot;
    logic [2:0]      ctype;
    logic [VL-1:0]   ctgt;
    logic [1:0]      cnt;

    logic [31:0]       s_ins [NS];
    longint unsigned   s_pc  [NS];
    logic [NS-1:0]     s_sv;

    longint unsigned ras_q[$];
    bit              e_valid, e_found, e_tv, e_rst;
    int              e_slot, e_type;
    longint unsigned e_tgt;
    int              checks, errors;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            instr[32*k +: 32] = s_ins[k];
            addr[VL*k +: VL]  = s_pc[k];
        end
        svalid = s_sv;
    end

    multi_instr_scan dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin), .ready_o(rdy_o),
        .instr_i(instr), .addr_i(addr), .slot_valid_i(svalid), .valid_o(vout),
        .ready_i(rdy_in), .cf_found_o(found), .cf_slot_o(cslot), .cf_type_o(ctype),
        .cf_target_o(ctgt), .cf_target_valid_o(ctv), .ras_count_o(cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint bitv(input int unsigned w, input int b);
        return longint'((w >> b) & 1);
    endfunction

    function automatic bit lnk(input int unsigned r);
        return (r == 1) || (r == 5);
    endfunction

    // Reference classification from the instruction-set rules, in plain arithmetic.
    function automatic void classify(input logic [31:0] ins, input longint unsigned pc,
                                     output int kind, output bit has_imm, output longint unsigned itgt,
                                     output bit push, output bit pop, output longint unsigned link);
        int unsigned w, opc, rd, rs1, c, f3;
        longint imm;
        w = ins; kind = 0; has_imm = 0; push = 0; pop = 0; imm = 0;
        if ((w & 3) == 3) begin
            link = pc + 4;
            opc = w & 127; rd = (w >> 7) & 31; rs1 = (w >> 15) & 31;
            if (opc == 'h63) begin
                kind = 1; has_imm = 1;
                imm = bitv(w,31) * -4096 + bitv(w,7) * 2048 + longint'((w >> 25) & 63) * 32
                      + longint'((w >> 8) & 15) * 2;
            end else if (opc == 'h6F) begin
                kind = lnk(rd) ? 3 : 2; push = lnk(rd); has_imm = 1;
                imm = bitv(w,31) * -(64'sd1 << 20) + longint'((w >> 12) & 255) * 4096
                      + bitv(w,20) * 2048 + longint'((w >> 21) & 1023) * 2;
            end else if (opc == 'h67) begin
                pop = lnk(rs1) && (rd != rs1); push = lnk(rd);
                kind = pop ? 4 : (push ? 3 : 5);
            end
        end else begin
            link = pc + 2;
            c = w & 'hFFFF; f3 = (c >> 13) & 7;
            if ((c & 3) == 1) begin
                if (f3 == 5 || (f3 == 1 && XL == 32)) begin
                    kind = (f3 == 5) ? 2 : 3; push = (f3 == 1); has_imm = 1;
                    imm = bitv(c,12) * -2048 + bitv(c,8) * 1024 + longint'((c >> 9) & 3) * 256
                          + bitv(c,6) * 128 + bitv(c,7) * 64 + bitv(c,2) * 32 + bitv(c,11) * 16
                          + longint'((c >> 3) & 7) * 2;
                end else if (f3 == 6 || f3 == 7) begin
                    kind = 1; has_imm = 1;
                    imm = bitv(c,12) * -256 + longint'((c >> 5) & 3) * 64 + bitv(c,2) * 32
                          + longint'((c >> 10) & 3) * 8 + longint'((c >> 3) & 3) * 2;
                end
            end else if ((c & 3) == 2 && f3 == 4 && ((c >> 2) & 31) == 0 && ((c >> 7) & 31) != 0) begin
                if (bitv(c,12) == 1) begin
                    kind = 3; push = 1;
                end else begin
                    pop = lnk((c >> 7) & 31); kind = pop ? 4 : 5;
                end
            end
        end
        itgt = pc + imm;
    endfunction

    task automatic model_step();
        bit ready_m, hi, pu, po;
        int kind;
        longint unsigned it, ln;
        ready_m = (!e_valid || rdy_in) && !flush && !rst;
        e_rst = rst;
        if (rst) begin
            e_valid = 0; e_found = 0; e_slot = 0; e_type = 0; e_tgt = 0; e_tv = 0;
            ras_q.delete();
        end else if (flush) begin
            e_valid = 0;
        end else if (vin && ready_m) begin
            e_valid = 1; e_found = 0; e_slot = 0; e_type = 0; e_tgt = 0; e_tv = 0;
            for (int k = 0; k < NS; k++) begin
                classify(s_ins[k], s_pc[k], kind, hi, it, pu, po, ln);
                if (s_sv[k] && kind != 0) begin
                    e_found = 1; e_slot = k; e_type = kind;
                    if (kind == 4) begin
                        if (ras_q.size() > 0) begin e_tgt = ras_q[$]; e_tv = 1; end
                    end else if (hi) begin
                        e_tgt = it; e_tv = 1;
                    end
                    if (po && ras_q.size() > 0) void'(ras_q.pop_back());
                    if (pu) begin
                        ras_q.push_back(ln);
                        if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
                    end
                    break;
                end
            end
        end else if (rdy_in) begin
            e_valid = 0;
        end
    endtask

    task automatic cycle(input string tag);
        #1;
        chk({tag, "_ready"}, 64'(rdy_o), 64'((!e_valid || rdy_in) && !flush && !rst));
        @(posedge clk);
        model_step();
        #1;
        chk({tag, "_valid"}, 64'(vout), 64'(e_valid));
        chk({tag, "_count"}, 64'(cnt), 64'(ras_q.size()));
        if (e_valid || e_rst) begin
            chk({tag, "_found"}, 64'(found), 64'(e_found));
            chk({tag, "_slot"}, 64'(cslot), 64'(e_slot));
            chk({tag, "_type"}, 64'(ctype), 64'(e_type));
            chk({tag, "_tvalid"}, 64'(ctv), 64'(e_tv));
            if (!(e_type == 4 && !e_tv)) chk({tag, "_target"}, ctgt, e_tgt);
        end
    endtask

    task automatic blk1(input logic [31:0] ins, input longint unsigned pc);
        for (int k = 0; k < NS; k++) begin
            s_ins[k] = 32'h13; s_pc[k] = pc + 64'(4 * k);
        end
        s_ins[0] = ins; s_sv = 4'b0001;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd1;
            1: return 5'd5;
            2: return 5'd0;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] gen_ins();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: ;
            1: w[6:0] = 7'h63;
            2: begin w[6:0] = 7'h6F; w[11:7] = pick_reg(); end
            3: begin w[6:0] = 7'h67; w[14:12] = 3'd0; w[11:7] = pick_reg(); w[19:15] = pick_reg(); end
            4: w = 32'h13;
            5: begin
                w[1:0] = 2'b01;
                case ($urandom_range(0, 3))
                    0: w[15:13] = 3'b101;
                    1: w[15:13] = 3'b110;
                    2: w[15:13] = 3'b111;
                    default: w[15:13] = 3'b001;
                endcase
            end
            6, 7: begin w[1:0] = 2'b10; w[15:13] = 3'b100; w[6:2] = 5'd0; w[11:7] = pick_reg(); end
            8: w[1:0] = 2'b00;
            default: w = 32'h13;
        endcase
        return w;
    endfunction

    initial begin
        checks = 0; errors = 0;
        e_valid = 0; e_found = 0; e_tv = 0; e_rst = 0; e_slot = 0; e_type = 0; e_tgt = 0;
        rst = 1; flush = 0; vin = 0; rdy_in = 1;
        blk1(32'h13, 64'h0);
        cycle("reset0");
        cycle("reset1");
        rst = 0;

        // call then return
        blk1(32'h13, 64'h80000000); s_ins[1] = 32'h008000EF; s_sv = 4'b1111; vin = 1;
        cycle("call");
        chk("call_type_k", 64'(ctype), 64'd3);
        chk("call_slot_k", 64'(cslot), 64'd1);
        chk("call_tgt_k", ctgt, 64'h8000000C);
        chk("call_cnt_k", 64'(cnt), 64'd1);
        blk1(32'h00008067, 64'h8000000C);
        cycle("ret");
        chk("ret_type_k", 64'(ctype), 64'd4);
        chk("ret_tgt_k", ctgt, 64'h80000008);
        chk("ret_tv_k", 64'(ctv), 64'd1);
        chk("ret_cnt_k", 64'(cnt), 64'd0);

        // branch shadows a later call
        blk1(32'hFE000EE3, 64'h1000); s_ins[2] = 32'h008000EF; s_sv = 4'b1111;
        cycle("branch");
        chk("br_tgt_k", ctgt, 64'hFFC);
        chk("br_cnt_k", 64'(cnt), 64'd0);

        // compressed return on empty stack
        blk1(32'h00008282, 64'h2000);
        cycle("cjr");
        chk("cjr_type_k", 64'(ctype), 64'd4);
        chk("cjr_tv_k", 64'(ctv), 64'd0);

        // overflow then drain
        for (int i = 1; i <= 3; i++) begin
            blk1(32'h008000EF, 64'(i * 'h100));
            cycle("ovf_call");
        end
        chk("ovf_cnt_k", 64'(cnt), 64'd2);
        blk1(32'h00008067, 64'h400);
        cycle("ovf_ret1");
        chk("ovf_ret1_k", ctgt, 64'h304);
        cycle("ovf_ret2");
        chk("ovf_ret2_k", ctgt, 64'h204);
        cycle("ovf_ret3");
        chk("ovf_ret3_tv_k", 64'(ctv), 64'd0);

        // backpressure, flush, reset mid-stall
        vin = 0;
        cycle("drain");
        vin = 1; rdy_in = 0; blk1(32'h0080006F, 64'h500);
        cycle("bp_load");
        blk1(32'h008000EF, 64'h600);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            chk("bp_ready_k", 64'(rdy_o), 64'd0);
            chk("bp_tgt_k", ctgt, 64'h508);
        end
        flush = 1; rdy_in = 1;
        cycle("flush");
        chk("flush_vld_k", 64'(vout), 64'd0);
        chk("flush_cnt_k", 64'(cnt), 64'd0);
        flush = 0;
        cycle("post_flush_call");
        rdy_in = 0; vin = 0;
        cycle("stall");
        rst = 1;
        cycle("rst_stall");
        chk("rst_stall_vld_k", 64'(vout), 64'd0);
        chk("rst_stall_cnt_k", 64'(cnt), 64'd0);
        rst = 0; rdy_in = 1;

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            rst    = ($urandom_range(0, 99) == 0);
            flush  = ($urandom_range(0, 19) == 0);
            vin    = ($urandom_range(0, 3) != 0);
            rdy_in = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NS; k++) begin
                s_ins[k] = gen_ins();
                s_pc[k]  = {$urandom, $urandom};
                s_pc[k][0] = 1'b0;
                s_sv[k]  = ($urandom_range(0, 3) != 0);
            end
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_instr_scan.md
MULTI_INSTR_SCAN -- requirements
Module: multi_instr_scan

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty; supplies VLEN (address width) and XLEN (32 enables C.JAL decode).
REQ-002 SHALL have parameter NR_SLOTS, default 4; number of realigned instruction slots per fetch block, minimum 1.
REQ-003 SHALL have parameter RAS_DEPTH, default 2; return-address-stack entries, minimum 1.
REQ-004 clk_i  in  1  clock; single clock domain, all state on rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 flush_i  in  1  kill the output register and block input acceptance this cycle.
REQ-007 valid_i  in  1  fetch block present.
REQ-008 ready_o  out  1  block accepted when valid_i & ready_o.
REQ-009 instr_i  in  NR_SLOTS*32  slot k instruction in bits [32k+31:32k]; a compressed instruction occupies the low 16 bits.
REQ-010 addr_i  in  NR_SLOTS*VLEN  slot k instruction address.
REQ-011 slot_valid_i  in  NR_SLOTS  per-slot valid.
REQ-012 valid_o  out  1  scan result present.
REQ-013 ready_i  in  1  consumer takes the result when valid_o & ready_i.
REQ-014 cf_found_o  out  1  a control-flow slot was found.
REQ-015 cf_slot_o  out  max(1,$clog2(NR_SLOTS))  index of that slot.
REQ-016 cf_type_o  out  3  0 NONE, 1 BRANCH, 2 JUMP, 3 CALL, 4 RETURN, 5 INDIRECT.
REQ-017 cf_target_o  out  VLEN  predicted target.
REQ-018 cf_target_valid_o  out  1  cf_target_o is meaningful.
REQ-019 ras_count_o  out  $clog2(RAS_DEPTH+1)  number of RAS entries that are occupied.

Function
REQ-020 A slot SHALL be compressed iff instr[1:0] != 2'b11.
REQ-021 Classification SHALL be as follows:
- BRANCH: opcode 1100011, C.BEQZ or C.BNEZ.
- CALL: JAL or JALR with rd in {x1,x5}; C.JALR; C.JAL when XLEN==32.
- RETURN: JALR with rs1 in {x1,x5} and rd != rs1; C.JR with rs1 in {x1,x5}.
- JUMP: any other JAL; C.J.
- INDIRECT: any other JALR or C.JR.
- NONE: everything else, including xRET.
REQ-022 An instruction that is both RETURN and CALL SHALL be typed RETURN and SHALL perform a pop then a push.
REQ-023 The scan SHALL select the lowest-index valid slot whose type is not NONE; higher slots SHALL be ignored; if there is none, cf_found_o=0, cf_type_o=0, cf_slot_o=0 and cf_target_valid_o=0.
REQ-024 For BRANCH, JUMP and JAL/C.JAL-CALL, the target SHALL be addr + sign-extended immediate (B/J/CB/CJ formats), modulo 2^VLEN, with cf_target_valid_o=1.
REQ-025 For a RETURN, the target SHALL be the RAS top as sampled at acceptance, with cf_target_valid_o=1 only if ras_count_o>0.
REQ-026 For INDIRECT, JALR-CALL and C.JALR, cf_target_valid_o SHALL be 0 and cf_target_o SHALL be 0.
REQ-027 The RAS SHALL be updated only on acceptance and only for the selected slot.
- CALL pushes addr+4 (addr+2 if compressed).
- RETURN pops.
REQ-028 A push when the RAS is full SHALL overwrite the oldest entry as a circular stack, with the count saturating at RAS_DEPTH.
REQ-029 A pop when the RAS is empty SHALL leave it unchanged.
REQ-030 Latency SHALL be 1 cycle: results accepted at edge N are visible at valid_o after edge N.
REQ-031 ready_o SHALL equal (~valid_o | ready_i) & ~flush_i & ~rst_i.
REQ-032 While valid_o & ~ready_i, all outputs SHALL hold stable.
REQ-033 flush_i SHALL clear valid_o at the next edge, accept no input that cycle, and leave RAS contents and count unchanged.
REQ-034 When ready_i and valid_i coincide with a valid output, the old result SHALL retire and the new one SHALL load in the same edge, giving full throughput.

Reset
REQ-035 On rst_i at a clock edge, the block SHALL set valid_o=0, all cf_* outputs to 0 and the RAS count to 0; this SHALL apply even mid-stall, and any in-flight result SHALL be discarded.
REQ-036 RAS entry storage need not be reset.

Verification
REQ-037 Call followed by return (NR_SLOTS=4, VLEN=64):
- slot0=0x00000013 @0x80000000, slot1=0x008000EF @0x80000004 -> CALL, slot 1, target 0x8000000C, ras_count_o=1.
- next block slot0=0x00008067 @0x8000000C -> RETURN, target 0x80000008, valid, ras_count_o=0.
REQ-038 Branch: 0xFE000EE3 @0x1000 -> BRANCH, target 0x0FFC; a later JAL in slot 2 is ignored and the RAS is unchanged.
REQ-039 Compressed return: 0x8282 (C.JR x5) with an empty RAS -> RETURN, cf_target_valid_o=0, ras_count_o stays 0.
REQ-040 RAS overflow (RAS_DEPTH=2):
- three JAL x1 calls at 0x100, 0x200, 0x300 -> count 2.
- returns then yield 0x304, then 0x204, then an invalid target.
REQ-041 Backpressure and flush:
- hold ready_i=0 for 3 cycles -> outputs stable and ready_o=0.
- assert flush_i together with valid_i -> valid_o=0 next cycle, no RAS change.
- assert rst_i mid-stall -> all outputs 0.
